// File: rtl/fc_pkg.sv
// Shared constants, FSM state type and Q8.8 requantisation helper for the
// fully-connected output layer.
package fc_pkg;

  localparam int DW            = 16;
  localparam int FRAC          = 8;
  localparam int N_OUT_CLASSES = 10;

  localparam logic signed [63:0] QMAX = (64'sd1 <<< (DW - 1)) - 64'sd1;
  localparam logic signed [63:0] QMIN = -(64'sd1 <<< (DW - 1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_LAST,
    S_STORE,
    S_FLAG,
    S_DONE
  } state_t;

  // Arithmetic shift back to Q8.8, clamp to the 16-bit range, optional ReLU.
  function automatic logic [DW-1:0] sat_q88(input logic signed [63:0] acc,
                                            input logic relu);
    logic signed [63:0] r;
    logic [DW-1:0]      q;
    r = acc >>> FRAC;
    if (r > QMAX)      q = QMAX[DW-1:0];
    else if (r < QMIN) q = QMIN[DW-1:0];
    else               q = r[DW-1:0];
    if (relu && r[63]) q = '0;
    return q;
  endfunction

endpackage

// File: rtl/fc_output_layer_mac.sv
// Registered signed multiply-accumulate with clear, bias-add mode and a
// requantised (shift/saturate/ReLU) view of the accumulator.
module fc_mac_unit
  import fc_pkg::*;
#(
  parameter int DW   = 16,
  parameter int FRAC = 8,
  parameter int ACCW = 40,
  parameter bit RELU = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 en,
  input  logic                 bias_mode,
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic [DW-1:0]        q
);

  logic signed [2*DW-1:0] prod;
  logic signed [ACCW-1:0] addend;
  logic signed [ACCW-1:0] acc;

  always_comb begin
    prod = a * b;
    if (bias_mode)
      addend = {{(ACCW - DW){b[DW-1]}}, b} <<< FRAC;
    else
      addend = {{(ACCW - 2*DW){prod[2*DW-1]}}, prod};
  end

  always_ff @(posedge clk) begin
    if (reset || clear)
      acc <= '0;
    else if (en)
      acc <= acc + addend;
  end

  assign q = sat_q88({{(64 - ACCW){acc[ACCW-1]}}, acc}, RELU);

endmodule

// File: rtl/fc_output_layer.sv
// Final fully-connected layer: one time-multiplexed MAC walks N_OUT neurons,
// each reading N_IN feature/weight pairs plus a bias from synchronous memories.
module fc_output_layer
  import fc_pkg::*;
#(
  parameter int N_IN  = 84,
  parameter int N_OUT = 10,
  parameter int DW    = fc_pkg::DW,
  parameter int FRAC  = fc_pkg::FRAC,
  parameter int ACCW  = 40,
  parameter int RELU  = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 mem_en,
  output logic [$clog2(N_IN)-1:0]              in_addr,
  input  logic [DW-1:0]                        in_data,
  output logic [$clog2(N_OUT*(N_IN+1))-1:0]    w_addr,
  input  logic [DW-1:0]                        w_data,
  output logic [N_OUT*DW-1:0]                  out_vec,
  output logic                                 busy,
  output logic                                 done_pulse,
  output logic                                 done
);

  localparam int IAW = $clog2(N_IN);
  localparam int WAW = $clog2(N_OUT * (N_IN + 1));
  localparam int JW  = $clog2(N_IN + 1);
  localparam int KW  = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_t         state, state_n;
  logic [JW-1:0]  j;
  logic [KW-1:0]  k;
  logic [WAW-1:0] base;
  logic           last_k;
  logic           mac_clear;
  logic           mac_en;
  logic           mac_bias;
  logic [DW-1:0]  mac_q;

  assign last_k = (k == KW'(N_OUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    mac_clear = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n   = S_ISSUE;
          mac_clear = 1'b1;
        end
      end
      S_ISSUE: if (j == JW'(N_IN)) state_n = S_LAST;
      S_LAST:  state_n = S_STORE;
      S_STORE: begin
        mac_clear = 1'b1;
        state_n   = last_k ? S_FLAG : S_ISSUE;
      end
      S_FLAG:  state_n = S_DONE;
      default: state_n = S_IDLE;
    endcase
  end

  // Per-neuron base address advances by N_IN+1, so no address multiplier.
  always_ff @(posedge clk) begin
    if (reset) begin
      k       <= '0;
      j       <= '0;
      base    <= '0;
      out_vec <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            k    <= '0;
            j    <= '0;
            base <= '0;
          end
        end
        S_ISSUE: j <= j + JW'(1);
        S_STORE: begin
          for (int unsigned i = 0; i < N_OUT; i++)
            if (k == KW'(i)) out_vec[i*DW +: DW] <= mac_q;
          if (!last_k) begin
            k    <= k + KW'(1);
            j    <= '0;
            base <= base + WAW'(N_IN + 1);
          end
        end
        default: ;
      endcase
    end
  end

  // Read data lags the address by one cycle: products land on ISSUE j>=1,
  // the bias word lands on LAST.
  assign mac_en   = ((state == S_ISSUE) && (j != '0)) || (state == S_LAST);
  assign mac_bias = (state == S_LAST);

  fc_mac_unit #(
    .DW   (DW),
    .FRAC (FRAC),
    .ACCW (ACCW),
    .RELU (RELU != 0)
  ) u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear     (mac_clear),
    .en        (mac_en),
    .bias_mode (mac_bias),
    .a         (in_data),
    .b         (w_data),
    .q         (mac_q)
  );

  assign mem_en     = (state == S_ISSUE);
  assign in_addr    = (j < JW'(N_IN)) ? j[IAW-1:0] : '0;
  assign w_addr     = base + WAW'(j);
  assign busy       = (state == S_ISSUE) || (state == S_LAST) || (state == S_STORE);
  assign done_pulse = (state == S_FLAG);
  assign done       = (state == S_DONE);

endmodule

// File: tb/tb_fc_output_layer.sv
// Bench for fc_output_layer: two small instances (RELU on/off) and one default
// instance, checked every cycle against a latency/arithmetic model.
module tb_fc_output_layer;

  localparam int SN_IN  = 4;
  localparam int SN_OUT = 3;
  localparam int SLAT   = SN_OUT * (SN_IN + 3);
  localparam int BN_IN  = 84;
  localparam int BN_OUT = 10;
  localparam int BLAT   = BN_OUT * (BN_IN + 3);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_s = 1'b0;
  logic start_c = 1'b0;
  logic armed = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  logic signed [15:0] sf [SN_IN];
  logic signed [15:0] sw [SN_OUT*(SN_IN+1)];
  logic signed [15:0] bf [BN_IN];
  logic signed [15:0] bw [BN_OUT*(BN_IN+1)];

  logic        a_en, a_busy, a_dp, a_done;
  logic [1:0]  a_ia;
  logic [3:0]  a_wa;
  logic [15:0] a_id, a_wd;
  logic [47:0] a_vec;
  logic        b_en, b_busy, b_dp, b_done;
  logic [1:0]  b_ia;
  logic [3:0]  b_wa;
  logic [15:0] b_id, b_wd;
  logic [47:0] b_vec;
  logic        c_en, c_busy, c_dp, c_done;
  logic [6:0]  c_ia;
  logic [9:0]  c_wa;
  logic [15:0] c_id, c_wd;
  logic [159:0] c_vec;

  fc_output_layer #(.N_IN(SN_IN), .N_OUT(SN_OUT), .RELU(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_s), .mem_en(a_en), .in_addr(a_ia),
    .in_data(a_id), .w_addr(a_wa), .w_data(a_wd), .out_vec(a_vec),
    .busy(a_busy), .done_pulse(a_dp), .done(a_done));

  fc_output_layer #(.N_IN(SN_IN), .N_OUT(SN_OUT), .RELU(0)) dut_b (
    .clk(clk), .reset(reset), .start(start_s), .mem_en(b_en), .in_addr(b_ia),
    .in_data(b_id), .w_addr(b_wa), .w_data(b_wd), .out_vec(b_vec),
    .busy(b_busy), .done_pulse(b_dp), .done(b_done));

  fc_output_layer dut_c (
    .clk(clk), .reset(reset), .start(start_c), .mem_en(c_en), .in_addr(c_ia),
    .in_data(c_id), .w_addr(c_wa), .w_data(c_wd), .out_vec(c_vec),
    .busy(c_busy), .done_pulse(c_dp), .done(c_done));

  always @(posedge clk) begin
    if (a_en) begin a_id <= sf[a_ia]; a_wd <= sw[a_wa]; end
    if (b_en) begin b_id <= sf[b_ia]; b_wd <= sw[b_wa]; end
    if (c_en) begin c_id <= bf[c_ia]; c_wd <= bw[c_wa]; end
  end

  // Dot product + bias in plain integer arithmetic, then Q8.8 requantise.
  function automatic logic [159:0] model(input bit big, input bit relu);
    int nin, nout;
    longint acc, r, f, w;
    logic [159:0] v;
    nin  = big ? BN_IN : SN_IN;
    nout = big ? BN_OUT : SN_OUT;
    v = '0;
    for (int k = 0; k < nout; k++) begin
      acc = 0;
      for (int j = 0; j <= nin; j++) begin
        if (big) w = bw[k*(nin+1)+j];
        else     w = sw[k*(nin+1)+j];
        if (j < nin) begin
          if (big) f = bf[j];
          else     f = sf[j];
          acc += f * w;
        end else begin
          acc += w * 256;
        end
      end
      r = acc >>> 8;
      if (r > 32767)  r = 32767;
      if (r < -32768) r = -32768;
      if (relu && r < 0) r = 0;
      v[k*16 +: 16] = r[15:0];
    end
    return v;
  endfunction

  // Edges since the accepted start (-1 = idle after reset), expected vectors.
  int t_s = -1;
  int t_c = -1;
  logic [47:0]  exp_a, exp_b;
  logic [159:0] exp_c;

  always @(posedge clk) begin
    logic [159:0] m;
    if (reset) begin
      t_s <= -1; t_c <= -1;
      exp_a <= '0; exp_b <= '0; exp_c <= '0;
    end else begin
      if (start_s && (t_s < 0 || t_s > SLAT)) t_s <= 0;
      else if (t_s >= 0) begin
        t_s <= t_s + 1;
        if (t_s + 1 == SLAT) begin
          m = model(1'b0, 1'b1); exp_a <= m[47:0];
          m = model(1'b0, 1'b0); exp_b <= m[47:0];
        end
      end
      if (start_c && (t_c < 0 || t_c > BLAT)) t_c <= 0;
      else if (t_c >= 0) begin
        t_c <= t_c + 1;
        if (t_c + 1 == BLAT) exp_c <= model(1'b1, 1'b1);
      end
    end
  end

  task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] ex);
    n_cmp++;
    if (act !== ex) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, ex, $time);
    end
  endtask

  task automatic chk_dut(input string nm, input int t, input int nin, input int nout,
                         input logic en, input logic busy, input logic dp, input logic dn,
                         input logic [9:0] ia, input logic [9:0] wa,
                         input logic [159:0] vec, input logic [159:0] ev);
    int  lat, p, kk;
    bit  run, iss;
    lat = nout * (nin + 3);
    run = (t >= 0) && (t < lat);
    p   = run ? t % (nin + 3) : 0;
    kk  = run ? t / (nin + 3) : 0;
    iss = run && (p <= nin);
    chk({nm, ".busy"}, busy, run);
    chk({nm, ".done_pulse"}, dp, t == lat);
    chk({nm, ".done"}, dn, t > lat);
    chk({nm, ".mem_en"}, en, iss);
    if (iss) begin
      chk({nm, ".in_addr"}, ia, (p < nin) ? p : 0);
      chk({nm, ".w_addr"}, wa, kk * (nin + 1) + p);
    end
    if (t < 0 || t >= lat) chk({nm, ".out_vec"}, vec, ev);
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk_dut("a", t_s, SN_IN, SN_OUT, a_en, a_busy, a_dp, a_done,
              10'(a_ia), 10'(a_wa), 160'(a_vec), 160'(exp_a));
      chk_dut("b", t_s, SN_IN, SN_OUT, b_en, b_busy, b_dp, b_done,
              10'(b_ia), 10'(b_wa), 160'(b_vec), 160'(exp_b));
      chk_dut("c", t_c, BN_IN, BN_OUT, c_en, c_busy, c_dp, c_done,
              10'(c_ia), c_wa, c_vec, exp_c);
    end
  end

  // Returns at the negedge after the accept edge (edge 0).
  task automatic pulse_s();
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
  endtask

  task automatic pulse_c();
    @(negedge clk); start_c = 1'b1;
    @(negedge clk); start_c = 1'b0;
  endtask

  task automatic fill_small(input logic [15:0] f, input logic [15:0] w, input logic [15:0] bias);
    for (int i = 0; i < SN_IN; i++) sf[i] = f;
    for (int k = 0; k < SN_OUT; k++)
      for (int j = 0; j <= SN_IN; j++) sw[k*(SN_IN+1)+j] = (j == SN_IN) ? bias : w;
  endtask

  initial begin
    fill_small(16'h0000, 16'h0000, 16'h0000);
    for (int i = 0; i < BN_IN; i++) bf[i] = '0;
    for (int i = 0; i < BN_OUT*(BN_IN+1); i++) bw[i] = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    armed = 1'b1;
    chk("reset.a_vec", a_vec, 0);

    // 1: unity data and weights -> 4.0 everywhere; flag timing pinned
    fill_small(16'h0100, 16'h0100, 16'h0000);
    pulse_s();
    repeat (SLAT) @(negedge clk);
    chk("t1.done_pulse@21", a_dp, 1);
    chk("t1.busy@21", a_busy, 0);
    @(negedge clk);
    chk("t1.done@22", a_done, 1);
    chk("t1.a_vec", a_vec, 48'h0400_0400_0400);

    // 2: neuron 1 negative
    for (int j = 0; j < SN_IN; j++) sw[SN_IN+1+j] = 16'hFF00;
    pulse_s();
    repeat (SLAT + 2) @(negedge clk);
    chk("t2.a_vec", a_vec, 48'h0400_0000_0400);
    chk("t2.b_vec", b_vec, 48'h0400_FC00_0400);

    // 3: saturation both directions
    fill_small(16'h7FFF, 16'h7FFF, 16'h7FFF);
    pulse_s();
    repeat (SLAT + 2) @(negedge clk);
    chk("t3.a_pos", a_vec, 48'h7FFF_7FFF_7FFF);
    chk("t3.b_pos", b_vec, 48'h7FFF_7FFF_7FFF);
    fill_small(16'h7FFF, 16'h8000, 16'h8000);
    pulse_s();
    repeat (SLAT + 2) @(negedge clk);
    chk("t3.a_neg", a_vec, 48'h0000_0000_0000);
    chk("t3.b_neg", b_vec, 48'h8000_8000_8000);

    // 4: bias only
    fill_small(16'h7FFF, 16'h0000, 16'h0000);
    sw[4] = 16'h0280; sw[9] = 16'h0010; sw[14] = 16'h0000;
    pulse_s();
    repeat (SLAT + 2) @(negedge clk);
    chk("t4.a_vec", a_vec, 48'h0000_0010_0280);
    chk("t4.b_vec", b_vec, 48'h0000_0010_0280);

    // 6: reset at edge 10, ignored start at edge 5, restart from DONE
    pulse_s();
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("t6.rst_vec", a_vec, 0);
    chk("t6.rst_busy", a_busy, 0);
    chk("t6.rst_mem_en", a_en, 0);
    chk("t6.rst_done", a_done, 0);
    pulse_s();
    repeat (4) @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    repeat (SLAT - 5) @(negedge clk);
    chk("t6.done_pulse@21", a_dp, 1);
    repeat (3) @(negedge clk);
    chk("t6.a_vec", a_vec, 48'h0000_0010_0280);
    pulse_s();
    chk("t6.restart_done", a_done, 0);
    chk("t6.restart_busy", a_busy, 1);
    repeat (SLAT + 2) @(negedge clk);
    chk("t6.rerun_vec", b_vec, 48'h0000_0010_0280);

    // 5: default geometry, random Q8.8 values in +/-0.5, biases in +/-2.0
    for (int i = 0; i < BN_IN; i++) bf[i] = 16'($urandom_range(0, 255)) - 16'd128;
    for (int i = 0; i < BN_OUT*(BN_IN+1); i++)
      bw[i] = ((i % (BN_IN+1)) == BN_IN) ? 16'($urandom_range(0, 1023)) - 16'd512
                                         : 16'($urandom_range(0, 255)) - 16'd128;
    pulse_c();
    repeat (BLAT) @(negedge clk);
    chk("t5.done_pulse@870", c_dp, 1);
    @(negedge clk);
    chk("t5.done@871", c_done, 1);
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
